cam_lookup_ctrl: RTL and testbench

Request-side controller for the CAM block: accepts lookup, insert and read requests over a valid/ready handshake and drives the CAM's read, write and search ports. It returns hit, index and data on a response handshake. On an insert miss it allocates an entry round-robin, evicting once the table is full. It sits between the client datapath and the CAM, and is the only agent driving the CAM's enable inputs.

---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_lookup_ctrl_if.sv | 64 ++++++
 rtl/cam_alloc_ptr.sv | 34 +++
 rtl/cam_lookup_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cam_lookup_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM block and its request-side controller.
//   CAM_WIDTH / CAM_ADDR_WIDTH / CAM_HEIGHT : default geometry shared with the CAM
//   cam_op_e         : request opcodes (RSVD behaves as LOOKUP)
//   cam_ctrl_state_e : controller FSM states
package cam_pkg;

  localparam int CAM_WIDTH      = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_HEIGHT     = 32;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    INSERT = 2'd1,
    READ   = 2'd2,
    RSVD   = 2'd3
  } cam_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    WRITE,
    RESP
  } cam_ctrl_state_e;

endpackage

// File: rtl/cam_lookup_ctrl_if.sv
// Bundles for cam_lookup_ctrl.
//   cam_lookup_ctrl_if : client request/response handshake
//     slave  = controller side, master = client side
//   cam_port_if        : CAM read, write and search ports
//     master = controller side (drives enables), slave = CAM side
// Signal suffixes are from the controller's point of view.
interface cam_lookup_ctrl_if #(
  parameter int WIDTH      = cam_pkg::CAM_WIDTH,
  parameter int ADDR_WIDTH = cam_pkg::CAM_ADDR_WIDTH
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [WIDTH-1:0]      req_key_i;
  logic [ADDR_WIDTH-1:0] req_index_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic                  resp_hit_o;
  logic [ADDR_WIDTH-1:0] resp_index_o;
  logic [WIDTH-1:0]      resp_data_o;
  logic                  resp_inserted_o;
  logic                  resp_evicted_o;

  modport slave (
    input  req_valid_i, req_op_i, req_key_i, req_index_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_index_o, resp_data_o,
           resp_inserted_o, resp_evicted_o
  );

  modport master (
    output req_valid_i, req_op_i, req_key_i, req_index_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_index_o, resp_data_o,
           resp_inserted_o, resp_evicted_o
  );
endinterface

interface cam_port_if #(
  parameter int WIDTH      = cam_pkg::CAM_WIDTH,
  parameter int ADDR_WIDTH = cam_pkg::CAM_ADDR_WIDTH
);
  logic                  cam_read_enable_o;
  logic [ADDR_WIDTH-1:0] cam_read_index_o;
  logic                  cam_read_valid_i;
  logic [WIDTH-1:0]      cam_read_value_i;
  logic                  cam_write_enable_o;
  logic [ADDR_WIDTH-1:0] cam_write_index_o;
  logic [WIDTH-1:0]      cam_write_data_o;
  logic                  cam_search_enable_o;
  logic [WIDTH-1:0]      cam_search_data_o;
  logic                  cam_search_valid_i;
  logic [ADDR_WIDTH-1:0] cam_search_index_i;

  modport master (
    output cam_read_enable_o, cam_read_index_o, cam_write_enable_o, cam_write_index_o,
           cam_write_data_o, cam_search_enable_o, cam_search_data_o,
    input  cam_read_valid_i, cam_read_value_i, cam_search_valid_i, cam_search_index_i
  );

  modport slave (
    input  cam_read_enable_o, cam_read_index_o, cam_write_enable_o, cam_write_index_o,
           cam_write_data_o, cam_search_enable_o, cam_search_data_o,
    output cam_read_valid_i, cam_read_value_i, cam_search_valid_i, cam_search_index_i
  );
endinterface

// File: rtl/cam_alloc_ptr.sv
// Round-robin allocation pointer with a saturating occupancy count.
//   clk_i, rst_i : clock, synchronous active-high reset
//   advance_i    : one entry was written at ptr_o this cycle
//   ptr_o        : next entry to allocate, wraps HEIGHT-1 -> 0
//   full_o       : every entry has been written at least once since reset
module cam_alloc_ptr #(
  parameter int ADDR_WIDTH = cam_pkg::CAM_ADDR_WIDTH,
  parameter int HEIGHT     = cam_pkg::CAM_HEIGHT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic                  full_o
);

  // One extra bit so the count can represent HEIGHT == 2**ADDR_WIDTH.
  logic [ADDR_WIDTH:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_o <= '0;
      count <= '0;
    end else if (advance_i) begin
      ptr_o <= (ptr_o == ADDR_WIDTH'(HEIGHT - 1)) ? '0 : ptr_o + 1'b1;
      if (!full_o) count <= count + 1'b1;
    end
  end

  assign full_o = (count == (ADDR_WIDTH + 1)'(HEIGHT));

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Request-side controller for the CAM. Accepts LOOKUP / INSERT / READ
// requests, drives the CAM search, read and write ports (single-cycle,
// mutually exclusive, registered enables) and returns hit/index/data on a
// response handshake. INSERT misses allocate round-robin, evicting when full.
//   clk_i, rst_i : clock, synchronous active-high reset
//   client       : request/response handshake (cam_lookup_ctrl_if.slave)
//   cam          : CAM read/write/search ports (cam_port_if.master)
// One request in flight. CAM result latency is one cycle after the enable.
module cam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int HEIGHT     = CAM_HEIGHT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cam_lookup_ctrl_if.slave client,
  cam_port_if.master       cam
);

  typedef struct packed {
    logic                  hit;
    logic [ADDR_WIDTH-1:0] index;
    logic [WIDTH-1:0]      data;
    logic                  inserted;
    logic                  evicted;
  } resp_t;

  typedef struct packed {
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic [WIDTH-1:0]      wr_data;
    logic                  srch_en;
    logic [WIDTH-1:0]      srch_data;
  } cam_cmd_t;

  cam_ctrl_state_e       state_q, state_d;
  cam_op_e               op_q;
  logic [WIDTH-1:0]      key_q;
  logic [ADDR_WIDTH-1:0] index_q;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  resp_t                 resp_q, resp_d;
  cam_cmd_t              cmd_q, cmd_d;
  logic                  accept;
  logic                  alloc_advance;
  logic                  alloc_full;
  logic [ADDR_WIDTH-1:0] alloc_ptr;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return int'(idx) < HEIGHT;
  endfunction

  assign accept = client.req_valid_i && req_ready_q && (state_q == IDLE);

  cam_alloc_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .HEIGHT     (HEIGHT)
  ) u_alloc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (alloc_advance),
    .ptr_o     (alloc_ptr),
    .full_o    (alloc_full)
  );

  // Next-state logic also computes the next value of every registered output,
  // so CAM enables and response fields come straight from flops.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_d        = resp_q;
    cmd_d         = '0;
    alloc_advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          req_ready_d = 1'b0;
          if (cam_op_e'(client.req_op_i) == READ) begin
            // Out-of-range READs never touch the CAM.
            if (in_range(client.req_index_i)) begin
              cmd_d.rd_en    = 1'b1;
              cmd_d.rd_index = client.req_index_i;
            end
          end else begin
            cmd_d.srch_en   = 1'b1;
            cmd_d.srch_data = client.req_key_i;
          end
        end
      end

      ISSUE: begin
        if (op_q == READ && !in_range(index_q)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_d       = '0;
          resp_d.index = index_q;
        end else begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_d       = '0;
        if (op_q == READ) begin
          resp_d.hit   = cam.cam_read_valid_i;
          resp_d.index = index_q;
          resp_d.data  = cam.cam_read_value_i;
        end else if (cam.cam_search_valid_i) begin
          resp_d.hit   = 1'b1;
          resp_d.index = cam.cam_search_index_i;
        end else if (op_q == INSERT) begin
          state_d        = WRITE;
          resp_valid_d   = 1'b0;
          cmd_d.wr_en    = 1'b1;
          cmd_d.wr_index = alloc_ptr;
          cmd_d.wr_data  = key_q;
        end
        // LOOKUP / RSVD miss: hit=0, index=0 from the cleared resp_d.
      end

      WRITE: begin
        // alloc_ptr still points at the entry being written this cycle.
        state_d         = RESP;
        resp_valid_d    = 1'b1;
        resp_d          = '0;
        resp_d.index    = alloc_ptr;
        resp_d.inserted = 1'b1;
        resp_d.evicted  = alloc_full;
        alloc_advance   = 1'b1;
      end

      RESP: begin
        if (client.resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_d       = '0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      cmd_q        <= '0;
      op_q         <= LOOKUP;
      key_q        <= '0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      cmd_q        <= cmd_d;
      if (accept) begin
        op_q    <= cam_op_e'(client.req_op_i);
        key_q   <= client.req_key_i;
        index_q <= client.req_index_i;
      end
    end
  end

  assign client.req_ready_o     = req_ready_q;
  assign client.resp_valid_o    = resp_valid_q;
  assign client.resp_hit_o      = resp_q.hit;
  assign client.resp_index_o    = resp_q.index;
  assign client.resp_data_o     = resp_q.data;
  assign client.resp_inserted_o = resp_q.inserted;
  assign client.resp_evicted_o  = resp_q.evicted;

  assign cam.cam_read_enable_o   = cmd_q.rd_en;
  assign cam.cam_read_index_o    = cmd_q.rd_index;
  assign cam.cam_write_enable_o  = cmd_q.wr_en;
  assign cam.cam_write_index_o   = cmd_q.wr_index;
  assign cam.cam_write_data_o    = cmd_q.wr_data;
  assign cam.cam_search_enable_o = cmd_q.srch_en;
  assign cam.cam_search_data_o   = cmd_q.srch_data;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Self-checking bench for cam_lookup_ctrl. Two instances: HEIGHT=32 (main)
// and HEIGHT=20 (out-of-range READ and short-table wrap). A behavioural CAM
// answers the DUT's ports; a request-level model predicts each response.
module tb_cam_lookup_ctrl;

  localparam int W  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sel = 1'b0;   // 0 -> HEIGHT=32 instance, 1 -> HEIGHT=20 instance
  int   h   = 32;     // table height of the selected instance

  // Stimulus
  logic          req_valid = 1'b0;
  logic [1:0]    req_op    = '0;
  logic [W-1:0]  req_key   = '0;
  logic [AW-1:0] req_index = '0;
  logic          resp_ready = 1'b0;
  logic          rd_valid  = 1'b0;
  logic [W-1:0]  rd_value  = '0;
  logic          s_valid   = 1'b0;
  logic [AW-1:0] s_index   = '0;

  cam_lookup_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) cl_a ();
  cam_lookup_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) cl_b ();
  cam_port_if        #(.WIDTH(W), .ADDR_WIDTH(AW)) cp_a ();
  cam_port_if        #(.WIDTH(W), .ADDR_WIDTH(AW)) cp_b ();

  assign cl_a.req_valid_i  = req_valid & ~sel;
  assign cl_b.req_valid_i  = req_valid &  sel;
  assign cl_a.resp_ready_i = resp_ready & ~sel;
  assign cl_b.resp_ready_i = resp_ready &  sel;
  assign cl_a.req_op_i     = req_op;
  assign cl_b.req_op_i     = req_op;
  assign cl_a.req_key_i    = req_key;
  assign cl_b.req_key_i    = req_key;
  assign cl_a.req_index_i  = req_index;
  assign cl_b.req_index_i  = req_index;
  assign cp_a.cam_read_valid_i   = rd_valid;
  assign cp_b.cam_read_valid_i   = rd_valid;
  assign cp_a.cam_read_value_i   = rd_value;
  assign cp_b.cam_read_value_i   = rd_value;
  assign cp_a.cam_search_valid_i = s_valid;
  assign cp_b.cam_search_valid_i = s_valid;
  assign cp_a.cam_search_index_i = s_index;
  assign cp_b.cam_search_index_i = s_index;

  cam_lookup_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .HEIGHT(32)) dut (
    .clk_i (clk), .rst_i (rst), .client (cl_a), .cam (cp_a)
  );
  cam_lookup_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .HEIGHT(20)) dut_h20 (
    .clk_i (clk), .rst_i (rst), .client (cl_b), .cam (cp_b)
  );

  // Observed outputs of the selected instance
  logic          o_req_ready, o_resp_valid, o_hit, o_ins, o_evi;
  logic          o_rd_en, o_wr_en, o_s_en;
  logic [AW-1:0] o_index, o_rd_idx, o_wr_idx;
  logic [W-1:0]  o_data, o_wr_data, o_s_data;

  assign o_req_ready  = sel ? cl_b.req_ready_o     : cl_a.req_ready_o;
  assign o_resp_valid = sel ? cl_b.resp_valid_o    : cl_a.resp_valid_o;
  assign o_hit        = sel ? cl_b.resp_hit_o      : cl_a.resp_hit_o;
  assign o_index      = sel ? cl_b.resp_index_o    : cl_a.resp_index_o;
  assign o_data       = sel ? cl_b.resp_data_o     : cl_a.resp_data_o;
  assign o_ins        = sel ? cl_b.resp_inserted_o : cl_a.resp_inserted_o;
  assign o_evi        = sel ? cl_b.resp_evicted_o  : cl_a.resp_evicted_o;
  assign o_rd_en      = sel ? cp_b.cam_read_enable_o   : cp_a.cam_read_enable_o;
  assign o_rd_idx     = sel ? cp_b.cam_read_index_o    : cp_a.cam_read_index_o;
  assign o_wr_en      = sel ? cp_b.cam_write_enable_o  : cp_a.cam_write_enable_o;
  assign o_wr_idx     = sel ? cp_b.cam_write_index_o   : cp_a.cam_write_index_o;
  assign o_wr_data    = sel ? cp_b.cam_write_data_o    : cp_a.cam_write_data_o;
  assign o_s_en       = sel ? cp_b.cam_search_enable_o : cp_a.cam_search_enable_o;
  assign o_s_data     = sel ? cp_b.cam_search_data_o   : cp_a.cam_search_data_o;

  // Behavioural CAM contents and allocation model
  logic [W-1:0] tkey [32];
  bit           tvalid [32];
  int           m_ptr = 0;
  int           m_cnt = 0;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int search(input logic [W-1:0] k);
    for (int i = 0; i < h; i++)
      if (tvalid[i] && tkey[i] == k) return i;
    return -1;
  endfunction

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      tkey[i]   = '0;
      tvalid[i] = 1'b0;
    end
  endtask

  // CAM responder: result appears in the cycle after the enable.
  always begin : cam_model
    logic p_s, p_rd;
    int   sidx;
    logic [AW-1:0] ridx;
    @(negedge clk);
    p_s  = o_s_en;
    p_rd = o_rd_en;
    sidx = search(o_s_data);
    ridx = o_rd_idx;
    if (o_wr_en) begin
      tkey[o_wr_idx]   = o_wr_data;
      tvalid[o_wr_idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid  = p_s && (sidx >= 0);
    s_index  = (p_s && sidx >= 0) ? AW'(sidx) : AW'($urandom);
    rd_valid = p_rd && tvalid[ridx];
    rd_value = p_rd ? tkey[ridx] : $urandom;
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 64'(o_req_ready), 64'd1);
  endtask

  // One full transaction: predict, issue, track CAM traffic, check response.
  task automatic do_req(input logic [1:0] op, input logic [W-1:0] key,
                        input logic [AW-1:0] idx, input int hold);
    logic          e_hit, e_ins, e_evi;
    logic [AW-1:0] e_idx, e_widx;
    logic [W-1:0]  e_data;
    int            e_lat, e_s, e_rd, e_wr, hitix;
    int            lat, n_s, n_rd, n_wr, n_multi, n_rdy, unstable;
    logic [AW-1:0] widx, ridx;
    logic [W-1:0]  wdata, sdata;
    logic          r_hit, r_ins, r_evi;
    logic [AW-1:0] r_idx;
    logic [W-1:0]  r_data;

    e_hit = 0; e_ins = 0; e_evi = 0; e_idx = '0; e_widx = '0; e_data = '0;
    e_lat = 3; e_s = 0; e_rd = 0; e_wr = 0;
    if (op == 2'd2) begin
      e_idx = idx;
      if (int'(idx) >= h) begin
        e_lat = 2;
      end else begin
        e_rd   = 1;
        e_hit  = tvalid[idx];
        e_data = tkey[idx];
      end
    end else begin
      e_s   = 1;
      hitix = search(key);
      if (hitix >= 0) begin
        e_hit = 1;
        e_idx = AW'(hitix);
      end else if (op == 2'd1) begin
        e_wr   = 1;
        e_lat  = 4;
        e_ins  = 1;
        e_idx  = AW'(m_ptr);
        e_widx = AW'(m_ptr);
        e_evi  = (m_cnt == h);
        m_ptr  = (m_ptr + 1) % h;
        if (m_cnt < h) m_cnt++;
      end
    end

    wait_ready();
    req_valid = 1'b1; req_op = op; req_key = key; req_index = idx;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_key = $urandom; req_index = AW'($urandom);

    lat = 1; n_s = 0; n_rd = 0; n_wr = 0; n_multi = 0; n_rdy = 0;
    widx = '0; wdata = '0; sdata = '0; ridx = '0;
    while (!o_resp_valid && lat < 20) begin
      if (o_req_ready) n_rdy++;
      if (o_s_en) begin n_s++; sdata = o_s_data; end
      if (o_rd_en) begin n_rd++; ridx = o_rd_idx; end
      if (o_wr_en) begin n_wr++; widx = o_wr_idx; wdata = o_wr_data; end
      if (int'(o_s_en) + int'(o_rd_en) + int'(o_wr_en) > 1) n_multi++;
      @(negedge clk);
      lat++;
    end

    check("latency", 64'(lat), 64'(e_lat));
    check("search_pulses", 64'(n_s), 64'(e_s));
    check("read_pulses", 64'(n_rd), 64'(e_rd));
    check("write_pulses", 64'(n_wr), 64'(e_wr));
    check("enables_exclusive", 64'(n_multi), 64'd0);
    check("req_ready_busy", 64'(n_rdy), 64'd0);
    if (e_s != 0)  check("search_key", 64'(sdata), 64'(key));
    if (e_rd != 0) check("read_index", 64'(ridx), 64'(idx));
    if (e_wr != 0) begin
      check("write_index", 64'(widx), 64'(e_widx));
      check("write_data", 64'(wdata), 64'(key));
    end
    check("resp_valid", 64'(o_resp_valid), 64'd1);
    check("resp_hit", 64'(o_hit), 64'(e_hit));
    check("resp_index", 64'(o_index), 64'(e_idx));
    check("resp_data", 64'(o_data), 64'(e_data));
    check("resp_inserted", 64'(o_ins), 64'(e_ins));
    check("resp_evicted", 64'(o_evi), 64'(e_evi));
    check("req_ready_resp", 64'(o_req_ready), 64'd0);

    r_hit = o_hit; r_idx = o_index; r_data = o_data; r_ins = o_ins; r_evi = o_evi;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b1 || o_hit !== r_hit || o_index !== r_idx ||
          o_data !== r_data || o_ins !== r_ins || o_evi !== r_evi ||
          o_req_ready !== 1'b0 || o_s_en || o_rd_en || o_wr_en)
        unstable++;
    end
    check("resp_hold_stable", 64'(unstable), 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_dropped", 64'(o_resp_valid), 64'd0);
    check("req_ready_after_resp", 64'(o_req_ready), 64'd1);
  endtask

  // Reset with a request pending at the same time; it must not be accepted.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_op = 2'd1; req_key = 32'h0000_0077; resp_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    check("rst_req_ready", 64'(o_req_ready), 64'd1);
    check("rst_resp_fields", {o_resp_valid, o_hit, o_ins, o_evi, o_index}, 64'd0);
    check("rst_resp_data", 64'(o_data), 64'd0);
    check("rst_enables", {o_rd_en, o_wr_en, o_s_en, o_rd_idx, o_wr_idx}, 64'd0);
    check("rst_cam_data", {o_wr_data, o_s_data}, 64'd0);
    @(negedge clk);
    check("rst_no_accept", 64'(o_s_en), 64'd0);
    check("rst_still_ready", 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    int n;
    clear_table();

    // ---------------- HEIGHT = 32 instance ----------------
    do_reset(3);

    // Fill the table in order, then one more insert evicts entry 0.
    for (int i = 0; i < 32; i++) do_req(2'd1, 32'h1000_0000 + W'(i), '0, 0);
    do_req(2'd1, 32'h1000_0040, '0, 0);

    // Directed hits and reads.
    tkey[7] = 32'hDEAD_BEEF; tvalid[7] = 1'b1;
    do_req(2'd0, 32'hDEAD_BEEF, '0, 0);
    tkey[3] = 32'h0000_0005; tvalid[3] = 1'b1;
    do_req(2'd1, 32'h0000_0005, '0, 0);
    tkey[4] = 32'hA5A5_A5A5; tvalid[4] = 1'b1;
    do_req(2'd2, '0, 5'd4, 0);
    do_req(2'd0, 32'h1000_0005, '0, 5);    // response back-pressure
    do_req(2'd0, 32'h7777_0000, '0, 0);    // lookup miss
    do_req(2'd3, 32'hDEAD_BEEF, '0, 0);    // reserved op behaves as lookup

    // Randomized mix over a small key pool so hits, misses and evictions occur.
    for (int i = 0; i < 150; i++)
      do_req(2'($urandom_range(0, 3)), 32'h100 + W'($urandom_range(0, 47)),
             AW'($urandom), $urandom_range(0, 2));

    // Reset while the fourth insert is writing: response dropped, pointer restarts.
    do_reset(2);
    for (int i = 0; i < 3; i++) do_req(2'd1, 32'hC000_0000 + W'(i), '0, 0);
    wait_ready();
    req_valid = 1'b1; req_op = 2'd1; req_key = 32'hC000_0003; req_index = '0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!o_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_write_seen", 64'(o_wr_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    check("abort_quiet", {o_resp_valid, o_s_en, o_rd_en, o_wr_en}, 64'd0);
    @(negedge clk);
    check("abort_no_resp", 64'(o_resp_valid), 64'd0);
    do_req(2'd1, 32'hC000_0010, '0, 0);

    // ---------------- HEIGHT = 20 instance ----------------
    sel = 1'b1;
    h   = 20;
    clear_table();
    do_reset(2);
    do_req(2'd2, '0, 5'd25, 0);            // out of range: no CAM access
    do_req(2'd2, '0, 5'd31, 1);
    for (int i = 0; i < 21; i++) do_req(2'd1, 32'h2000_0000 + W'(i), '0, 0);
    do_req(2'd2, '0, 5'd19, 0);
    for (int i = 0; i < 40; i++)
      do_req(2'($urandom_range(0, 3)), 32'h2000_0000 + W'($urandom_range(0, 30)),
             AW'($urandom), $urandom_range(0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
